// File: rtl/baud_pkg.sv
// Shared definitions for the fractional baud-tick generator.
// Holds the default divisor for 12 MHz / (16 x 9600), the default widths and
// oversample ratio, and a constant-foldable ceil(log2) helper.
package baud_pkg;

  localparam int unsigned DIV_W_DEFAULT      = 16;
  localparam int unsigned FRAC_W_DEFAULT     = 4;
  localparam int unsigned OSR_DEFAULT        = 16;
  localparam int unsigned DEF_DIV_12M_9600   = 78;
  localparam int unsigned DEF_FRAC_12M_9600  = 2;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_gen_frac_if.sv
// Control/status bundle of the baud-tick generator.
// master: drives en/sync/load/div_int/div_frac, observes the ticks and status.
// slave : the generator itself.
interface baud_tick_gen_frac_if #(
  parameter int unsigned DIV_W  = baud_pkg::DIV_W_DEFAULT,
  parameter int unsigned FRAC_W = baud_pkg::FRAC_W_DEFAULT,
  parameter int unsigned PH_W   = 4
);
  logic              en;
  logic              sync;
  logic              load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   phase;
  logic              cfg_pending;
  logic              cfg_err;

  modport master (
    output en, sync, load, div_int, div_frac,
    input  os_tick, bit_tick, phase, cfg_pending, cfg_err
  );

  modport slave (
    input  en, sync, load, div_int, div_frac,
    output os_tick, bit_tick, phase, cfg_pending, cfg_err
  );
endinterface

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator.
// Ports: clk/reset (sync, active-high); step_i advances acc by act_frac_i
// modulo 2^FRAC_W; clear_i zeroes acc (wins over step_i); carry_c_o flags that
// the next step overflows, i.e. the current tick period is one cycle longer.
module baud_frac_acc import baud_pkg::*; #(
  parameter int unsigned FRAC_W = FRAC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [FRAC_W-1:0] act_frac_i,
  output logic              carry_c_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  assign sum       = {1'b0, acc_q} + {1'b0, act_frac_i};
  assign carry_c_o = sum[FRAC_W];

  always_comb begin
    acc_d = acc_q;
    if (clear_i)     acc_d = '0;
    else if (step_i) acc_d = sum[FRAC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_tick_gen_frac.sv
// Programmable fractional baud-tick generator.
// Produces os_tick with average period div_int + div_frac/2^FRAC_W cycles and
// bit_tick every OSR oversample ticks. Ports: clk, reset (sync, active-high),
// bus (slave): en/sync/load/div_int/div_frac in; os_tick/bit_tick (decoded
// from registered state), phase, cfg_pending, cfg_err out.
module baud_tick_gen_frac import baud_pkg::*; #(
  parameter int unsigned DIV_W    = DIV_W_DEFAULT,
  parameter int unsigned FRAC_W   = FRAC_W_DEFAULT,
  parameter int unsigned OSR      = OSR_DEFAULT,
  parameter int unsigned DEF_DIV  = DEF_DIV_12M_9600,
  parameter int unsigned DEF_FRAC = DEF_FRAC_12M_9600
) (
  input logic                 clk,
  input logic                 reset,
  baud_tick_gen_frac_if.slave bus
);

  localparam int unsigned PH_W = clog2(OSR);

  logic [DIV_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d, cnt_q, cnt_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
  logic              pend_q, pend_d, err_q, err_d;
  logic              carry, period_end, os_tick_c, load_ok, acc_clear;

  // With a carry the period is one cycle longer, so compare against act_int
  // instead of act_int-1; cnt never has to exceed DIV_W bits.
  assign period_end = carry ? (cnt_q == act_int_q)
                            : (cnt_q == act_int_q - DIV_W'(1));
  assign os_tick_c  = bus.en & ~bus.sync & period_end;
  assign load_ok    = bus.load & (bus.div_int >= DIV_W'(2));
  assign phase_inc  = (phase_q == PH_W'(OSR - 1)) ? '0 : phase_q + PH_W'(1);

  // acc restarts on sync and whenever a pending divisor is applied
  assign acc_clear = bus.sync | (pend_q & (os_tick_c | ~bus.en));

  baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk       (clk),
    .reset     (reset),
    .step_i    (os_tick_c),
    .clear_i   (acc_clear),
    .act_frac_i(act_frac_q),
    .carry_c_o (carry)
  );

  assign bus.os_tick     = os_tick_c;
  assign bus.bit_tick    = os_tick_c & (phase_q == PH_W'(OSR - 1));
  assign bus.phase       = phase_q;
  assign bus.cfg_pending = pend_q;
  assign bus.cfg_err     = err_q;

  // Next-state: sync > apply/tick > count, then load capture on top
  always_comb begin
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    err_d       = err_q;

    if (bus.sync) begin
      cnt_d   = '0;
      phase_d = '0;
      pend_d  = 1'b0;
      // a divisor loaded in the sync cycle is applied right away
      if (load_ok) begin
        act_int_d  = bus.div_int;
        act_frac_d = bus.div_frac;
      end else if (pend_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
      end
    end else if (os_tick_c) begin
      cnt_d   = '0;
      phase_d = phase_inc;
      if (pend_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
        pend_d     = 1'b0;
      end
    end else if (!bus.en) begin
      // idle: no tick will come, so apply the pending divisor now
      if (pend_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
        pend_d     = 1'b0;
        cnt_d      = '0;
        phase_d    = '0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // a load accepted here waits for the next tick, never the current one
    if (bus.load) begin
      err_d = ~load_ok;
      if (load_ok && !bus.sync) begin
        pend_int_d  = bus.div_int;
        pend_frac_d = bus.div_frac;
        pend_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_int_q   <= DIV_W'(DEF_DIV);
      act_frac_q  <= FRAC_W'(DEF_FRAC);
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed bench for baud_tick_gen_frac with hand-computed tick intervals.
module tb_baud_tick_gen_frac;

  localparam int LIMIT = 2000;

  logic clk;
  logic reset;

  baud_tick_gen_frac_if #(.DIV_W(16), .FRAC_W(4), .PH_W(4)) bus ();

  baud_tick_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OSR(16), .DEF_DIV(78), .DEF_FRAC(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] s_os, s_bit, s_phase, s_pend, s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge with current inputs, commit at posedge,
  // then drop the single-cycle pulses.
  task automatic clk_cycle();
    @(negedge clk);
    s_os    = 32'(bus.os_tick);
    s_bit   = 32'(bus.bit_tick);
    s_phase = 32'(bus.phase);
    s_pend  = 32'(bus.cfg_pending);
    s_err   = 32'(bus.cfg_err);
    @(posedge clk);
    #1;
    bus.sync = 1'b0;
    bus.load = 1'b0;
  endtask

  // Cycles up to and including the next os_tick cycle
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      clk_cycle();
      n++;
    end while (s_os == 0 && n < LIMIT);
    if (s_os == 0) chk("tick_timeout", 0, 1);
  endtask

  task automatic run_cycles(input int k, output int nt);
    nt = 0;
    repeat (k) begin
      clk_cycle();
      if (s_os != 0) nt++;
    end
  endtask

  task automatic do_load(input int di, input int df);
    bus.load     = 1'b1;
    bus.div_int  = 16'(di);
    bus.div_frac = 4'(df);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nt, sum, nbit;
    reset = 1'b1;
    bus.en = 1'b0; bus.sync = 1'b0; bus.load = 1'b0;
    bus.div_int = '0; bus.div_frac = '0;
    repeat (3) clk_cycle();
    chk("rst_os", s_os, 0);
    chk("rst_bit", s_bit, 0);
    chk("rst_phase", s_phase, 0);
    chk("rst_pend", s_pend, 0);
    chk("rst_err", s_err, 0);

    // Defaults 78 + 2/16: every 8th interval is 79
    reset = 1'b0;
    bus.en = 1'b1;
    sum = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      sum += n;
      chk("def_intv", 32'(n), (k % 8 == 0) ? 79 : 78);
      chk("def_phase", s_phase, 32'(k - 1));
      chk("def_bit", s_bit, (k == 16) ? 1 : 0);
    end
    chk("def_first_bit", 32'(sum), 1250);
    sum = 0; nbit = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      sum += n;
      if (k == 1) chk("def_wrap_phase", s_phase, 0);
      if (s_bit != 0) nbit++;
    end
    chk("def_bit_period", 32'(sum), 1250);
    chk("def_bit_last", s_bit, 1);
    chk("def_bit_count", 32'(nbit), 1);

    // Load 5/0 mid-period: applied at the next tick
    run_cycles(30, nt);
    chk("mid_noticks", 32'(nt), 0);
    do_load(5, 0);
    clk_cycle();
    clk_cycle();
    chk("mid_pend", s_pend, 1);
    wait_tick(n);
    chk("mid_intv_old", 32'(n), 46);
    chk("mid_pend_at_tick", s_pend, 1);
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      chk("mid_intv_new", 32'(n), 5);
    end
    chk("mid_pend_clr", s_pend, 0);

    // Rejected load, then an accepted one clears the error
    do_load(1, 3);
    clk_cycle();
    clk_cycle();
    chk("rej_err", s_err, 1);
    chk("rej_pend", s_pend, 0);
    wait_tick(n);
    chk("rej_intv_a", 32'(n), 3);
    wait_tick(n);
    chk("rej_intv_b", 32'(n), 5);
    do_load(10, 0);
    clk_cycle();
    clk_cycle();
    chk("ok_err_clr", s_err, 0);
    chk("ok_pend", s_pend, 1);
    wait_tick(n);
    chk("ok_intv_a", 32'(n), 3);
    wait_tick(n);
    chk("ok_intv_b", 32'(n), 10);

    // Load coinciding with an os_tick waits one extra period
    do_load(78, 2);
    clk_cycle();
    wait_tick(n);
    chk("restore_intv", 32'(n), 9);
    run_cycles(77, nt);
    chk("coin_noticks", 32'(nt), 0);
    do_load(5, 0);
    clk_cycle();
    chk("coin_tick", s_os, 1);
    wait_tick(n);
    chk("coin_intv_old", 32'(n), 78);
    chk("coin_pend", s_pend, 1);
    wait_tick(n);
    chk("coin_intv_new", 32'(n), 5);

    // sync at phase 7, cnt 40
    do_load(78, 2);
    clk_cycle();
    wait_tick(n);
    chk("restore2_intv", 32'(n), 4);
    bus.sync = 1'b1;
    clk_cycle();
    for (int k = 0; k < 7; k++) begin
      wait_tick(n);
      chk("pre_sync_intv", 32'(n), 78);
    end
    run_cycles(40, nt);
    chk("pre_sync_noticks", 32'(nt), 0);
    bus.sync = 1'b1;
    clk_cycle();
    chk("sync_phase", s_phase, 7);
    chk("sync_os", s_os, 0);
    sum = 0; nbit = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      sum += n;
      if (k == 1) begin
        chk("sync_first_intv", 32'(n), 78);
        chk("sync_first_phase", s_phase, 0);
      end
      if (s_bit != 0) nbit++;
    end
    chk("sync_bit_span", 32'(sum), 1250);
    chk("sync_bit_last", s_bit, 1);
    chk("sync_bit_count", 32'(nbit), 1);

    // sync exactly in a tick cycle suppresses that tick
    run_cycles(77, nt);
    chk("mask_noticks", 32'(nt), 0);
    bus.sync = 1'b1;
    clk_cycle();
    chk("mask_os", s_os, 0);
    wait_tick(n);
    chk("mask_intv", 32'(n), 78);

    // sync with a load in the same cycle applies it at once
    bus.sync = 1'b1;
    do_load(6, 0);
    clk_cycle();
    wait_tick(n);
    chk("sync_load_intv", 32'(n), 6);
    chk("sync_load_pend", s_pend, 0);
    bus.sync = 1'b1;
    do_load(78, 2);
    clk_cycle();
    wait_tick(n);
    chk("sync_load_back", 32'(n), 78);

    // en low for 100 cycles holds cnt and phase
    run_cycles(20, nt);
    bus.en = 1'b0;
    run_cycles(100, nt);
    chk("en_off_ticks", 32'(nt), 0);
    chk("en_off_phase", s_phase, 1);
    bus.en = 1'b1;
    wait_tick(n);
    chk("en_resume_intv", 32'(n), 58);
    chk("en_resume_phase", s_phase, 1);

    // Reset with a pending load restores defaults
    do_load(5, 0);
    clk_cycle();
    reset = 1'b1;
    clk_cycle();
    chk("pre_rst_pend", s_pend, 1);
    clk_cycle();
    chk("mid_rst_pend", s_pend, 0);
    chk("mid_rst_phase", s_phase, 0);
    chk("mid_rst_os", s_os, 0);
    chk("mid_rst_err", s_err, 0);
    reset = 1'b0;
    wait_tick(n);
    chk("post_rst_intv", 32'(n), 78);
    chk("post_rst_pend", s_pend, 0);
    wait_tick(n);
    chk("post_rst_intv2", 32'(n), 78);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_frac.md
# baud_tick_gen_frac

Programmable fractional baud-tick generator: the next generation of the UART oversampling tick source. It produces an oversample tick (`os_tick`) whose average period is div_int + div_frac/2^FRAC_W clock cycles, and a bit tick (`bit_tick`) every OSR oversample ticks. The divisor can be reloaded at runtime without glitches, and a `sync` input re-phases the generator so the receiver can align to a start bit. It sits between the system clock and the UART rx/tx state machines.

## Interface
- DIV_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor; the fraction unit is 1/2^FRAC_W.
- OSR, 16, oversample ticks per bit tick; must be ≥2.
- DEF_DIV, 78, integer divisor after reset; must be ≥2. With DEF_FRAC this gives 12 MHz / (16 × 9600).
- DEF_FRAC, 2, fractional divisor after reset.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low, cnt/acc/phase hold.
- sync  in  1  single-cycle pulse; restarts the counter, accumulator and phase.
- load  in  1  single-cycle pulse; captures div_int/div_frac as the pending divisor.
- div_int  in  DIV_W  requested integer divisor.
- div_frac  in  FRAC_W  requested fractional divisor.
- os_tick  out  1  oversample tick, one cycle wide.
- bit_tick  out  1  bit tick, one cycle wide, coincident with an os_tick.
- phase  out  PH_W=clog2(OSR)  oversample index within the current bit.
- cfg_pending  out  1  a loaded divisor is waiting to be applied.
- cfg_err  out  1  sticky flag: the last load was rejected.

## Operation
- State:
  - act_int/act_frac: active divisor.
  - pend_int/pend_frac/pend: pending divisor and its valid flag.
  - cnt: DIV_W bits.
  - acc: FRAC_W bits.
  - phase.
  - cfg_err.
- carry = (acc + act_frac) ≥ 2^FRAC_W.
- Period end: cnt == act_int−1 when carry=0, or cnt == act_int when carry=1. Comparing this way means cnt never needs more than DIV_W bits.
- os_tick = en & ~sync & period_end. This is a combinational decode of registered state.
- bit_tick = os_tick & (phase == OSR−1).
- On an os_tick:
  - cnt←0.
  - acc←(acc+act_frac) mod 2^FRAC_W.
  - phase←(phase+1) mod OSR.
- On any other cycle with en=1: cnt←cnt+1.
- Load:
  - div_int ≥ 2: pend_*←inputs, pend←1, cfg_err←0. A later load overwrites an unapplied pending value.
  - div_int < 2: rejected, cfg_err←1; active and pending values unchanged.
- Apply pending (pend=1):
  - Takes effect at the edge ending an os_tick cycle. act←pend, acc←0, pend←0; cnt and phase update as for a normal tick.
  - If en=0, it applies at the next edge with cnt←0, acc←0, phase←0.
  - A load accepted in the same cycle as an os_tick applies at the following os_tick, not the current one.
- sync:
  - At the next edge: cnt←0, acc←0, phase←0.
  - os_tick and bit_tick are forced 0 in the sync cycle.
  - A pending divisor (including one loaded in the same cycle) is applied at the sync edge.
- Priority: reset > sync > pending-apply/tick > count.
- en=0: outputs low; state holds except for load/apply handling.

## Timing
- Reset values:
  - act=DEF_DIV/DEF_FRAC; pend=0; cnt=0; acc=0; phase=0.
  - os_tick=0, bit_tick=0, cfg_pending=0, cfg_err=0.
- With en=1 held from the first edge after reset, the first os_tick occurs in the cycle where cnt=DEF_DIV−1 (or DEF_DIV if carry=1).
- os_tick spacing is act_int or act_int+1 cycles.
- Over 2^FRAC_W ticks, the total is exactly act_int·2^FRAC_W + act_frac cycles.
- cfg_pending and cfg_err update one edge after load.
- sync to next os_tick: act_int cycles (or act_int+1 if act_frac·1 overflows, i.e. never, since acc=0 and act_frac<2^FRAC_W).
- Reset mid-operation discards the pending divisor and restores the defaults.

## Structure
- Shared package `baud_pkg`:
  - clog2 function.
  - Default constants DEF_DIV_12M_9600=78 and DEF_FRAC_12M_9600=2 (FRAC_W=4).
  - OSR_DEFAULT=16.
- Sub-module `baud_frac_acc`: holds acc, takes act_frac, exposes carry, and has step/clear inputs. Everything else stays in the top module.

## Test plan
- Defaults, en=1: os_tick intervals repeat as 78,78,78,78,78,78,78,79 (625 cycles per 8 ticks); bit_tick interval is exactly 1250 cycles; phase wraps 15→0 on bit_tick.
- Load div_int=5, div_frac=0 mid-period: cfg_pending=1 until the next os_tick; every interval after that is exactly 5; cfg_pending returns to 0.
- Load div_int=1: cfg_err=1, cfg_pending unchanged, intervals unchanged. A subsequent load of div_int=10 clears cfg_err.
- Load div_int=5 in the same cycle as an os_tick: the next interval is still 78 or 79, and the one after it is 5.
- sync at phase=7, cnt=40: no os_tick in the sync cycle; the next os_tick comes 78 cycles later with phase 0→1; bit_tick arrives 16 ticks after sync.
- en low for 100 cycles: no ticks, and cnt/phase are held. Reset asserted with a pending load: all outputs return to reset values and the first tick arrives at the 78th cycle.
